// File: rtl/flop_stim_gen_if.sv
// Signal bundle between a bench/BIST controller and flop_stim_gen.
// Inject/violation signals exist only when FLOP_STIM_VIOL_INJ_EN is defined.
interface flop_stim_gen_if #(
    parameter int CNT_W  = 16,
    parameter int PAT_W  = 32,
    parameter int EDGE_W = 16
);
    logic              start;
    logic [CNT_W-1:0]  cfg_low;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_setup;
    logic [CNT_W-1:0]  cfg_ctrl;
    logic [EDGE_W-1:0] cfg_edges;
    logic [PAT_W-1:0]  cfg_pat;
    logic              tclk;
    logic              td;
    logic              tclr_n;
    logic              tset_n;
    logic              exp_q;
    logic [EDGE_W-1:0] edge_cnt;
    logic              busy;
    logic              done;
`ifdef FLOP_STIM_VIOL_INJ_EN
    logic              inject;
    logic              viol_exp;
`endif

    modport master (
        output start, cfg_low, cfg_high, cfg_setup, cfg_ctrl, cfg_edges, cfg_pat,
`ifdef FLOP_STIM_VIOL_INJ_EN
        output inject,
        input  viol_exp,
`endif
        input  tclk, td, tclr_n, tset_n, exp_q, edge_cnt, busy, done
    );

    modport slave (
        input  start, cfg_low, cfg_high, cfg_setup, cfg_ctrl, cfg_edges, cfg_pat,
`ifdef FLOP_STIM_VIOL_INJ_EN
        input  inject,
        output viol_exp,
`endif
        output tclk, td, tclr_n, tset_n, exp_q, edge_cnt, busy, done
    );
endinterface

// File: rtl/flop_stim_gen.sv
// Stimulus sequencer for a clear/set D flop: clear/set pulses, programmable tclk, data with setup offset, expected q.
// Optional setup-violation injection is enabled by defining FLOP_STIM_VIOL_INJ_EN.
module flop_stim_gen #(
    parameter int CNT_W  = 16,
    parameter int PAT_W  = 32,
    parameter int EDGE_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    flop_stim_gen_if.slave stim_io
);
    typedef enum logic [2:0] {IDLE, CLR, SET, LOW, HIGH, FIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cfgLow_q, cfgLow_d, cfgHigh_q, cfgHigh_d;
    logic [CNT_W-1:0]  cfgSetup_q, cfgSetup_d, cfgCtrl_q, cfgCtrl_d;
    logic [EDGE_W-1:0] cfgEdges_q, cfgEdges_d, edgeCnt_q, edgeCnt_d;
    logic [PAT_W-1:0]  shadow_q, shadow_d;
    logic              tclk_q, tclk_d, td_q, td_d, tclrN_q, tclrN_d, tsetN_q, tsetN_d;
    logic              expQ_q, expQ_d, busy_q, busy_d, done_q, done_d;
    logic              goLow, goFin, holdTd;

    logic              idle;
    logic [CNT_W-1:0]  lowSel, highSel, setupSel, ctrlSel, lowLen, highLen;
    logic [EDGE_W-1:0] edgesSel;
    logic [PAT_W-1:0]  patSel;

    // In IDLE the start cycle works from the live config, later from the latched copy.
    assign idle     = (state_q == IDLE);
    assign lowSel   = idle ? stim_io.cfg_low   : cfgLow_q;
    assign highSel  = idle ? stim_io.cfg_high  : cfgHigh_q;
    assign setupSel = idle ? stim_io.cfg_setup : cfgSetup_q;
    assign ctrlSel  = idle ? stim_io.cfg_ctrl  : cfgCtrl_q;
    assign edgesSel = idle ? stim_io.cfg_edges : cfgEdges_q;
    assign patSel   = idle ? stim_io.cfg_pat   : shadow_q;
    assign lowLen   = (lowSel  == '0) ? CNT_W'(1) : lowSel;
    assign highLen  = (highSel == '0) ? CNT_W'(1) : highSel;

`ifdef FLOP_STIM_VIOL_INJ_EN
    logic armed_q, armed_d, viol_q, viol_d, armNow;
    assign armNow = armed_q | (stim_io.inject & busy_q);
    assign holdTd = armNow;
`else
    assign holdTd = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cfgLow_d   = cfgLow_q;
        cfgHigh_d  = cfgHigh_q;
        cfgSetup_d = cfgSetup_q;
        cfgCtrl_d  = cfgCtrl_q;
        cfgEdges_d = cfgEdges_q;
        edgeCnt_d  = edgeCnt_q;
        shadow_d   = shadow_q;
        tclk_d     = tclk_q;
        td_d       = td_q;
        tclrN_d    = tclrN_q;
        tsetN_d    = tsetN_q;
        expQ_d     = expQ_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        goLow      = 1'b0;
        goFin      = 1'b0;
`ifdef FLOP_STIM_VIOL_INJ_EN
        armed_d    = armNow;
        viol_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (stim_io.start) begin
                    cfgLow_d   = stim_io.cfg_low;
                    cfgHigh_d  = stim_io.cfg_high;
                    cfgSetup_d = stim_io.cfg_setup;
                    cfgCtrl_d  = stim_io.cfg_ctrl;
                    cfgEdges_d = stim_io.cfg_edges;
                    shadow_d   = stim_io.cfg_pat;
                    edgeCnt_d  = '0;
                    busy_d     = 1'b1;
                    if (stim_io.cfg_ctrl != '0) begin
                        state_d = CLR;
                        cnt_d   = stim_io.cfg_ctrl - CNT_W'(1);
                        tclrN_d = 1'b0;
                        expQ_d  = 1'b0;
                    end else if (stim_io.cfg_edges != '0) begin
                        goLow = 1'b1;
                    end else begin
                        goFin = 1'b1;
                    end
                end
            end
            CLR: begin
                if (cnt_q == '0) begin
                    state_d = SET;
                    cnt_d   = ctrlSel - CNT_W'(1);
                    tclrN_d = 1'b1;
                    tsetN_d = 1'b0;
                    expQ_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SET: begin
                if (cnt_q == '0) begin
                    tsetN_d = 1'b1;
                    if (edgesSel != '0) goLow = 1'b1;
                    else                goFin = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                if ((cnt_q == setupSel) && !holdTd) td_d = shadow_q[0];
                if (cnt_q == '0) begin
                    state_d   = HIGH;
                    cnt_d     = highLen - CNT_W'(1);
                    tclk_d    = 1'b1;
                    edgeCnt_d = (edgeCnt_q == '1) ? edgeCnt_q : edgeCnt_q + EDGE_W'(1);
                    expQ_d    = shadow_q[0];
                    shadow_d  = {shadow_q[0], shadow_q[PAT_W-1:1]};
`ifdef FLOP_STIM_VIOL_INJ_EN
                    // Injected edge: data moves with the clock, so the flop's capture is not trusted.
                    if (armNow) begin
                        td_d    = shadow_q[0];
                        expQ_d  = 1'b0;
                        viol_d  = 1'b1;
                        armed_d = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    if (edgeCnt_q == edgesSel) goFin = 1'b1;
                    else                       goLow = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A setup window at least as long as the low phase puts the data change on LOW entry.
        if (goLow) begin
            state_d = LOW;
            cnt_d   = lowLen - CNT_W'(1);
            tclk_d  = 1'b0;
            if ((setupSel >= lowLen) && !holdTd) td_d = patSel[0];
        end
        if (goFin) begin
            state_d = FIN;
            tclk_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`ifdef FLOP_STIM_VIOL_INJ_EN
            armed_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cfgLow_q   <= '0;
            cfgHigh_q  <= '0;
            cfgSetup_q <= '0;
            cfgCtrl_q  <= '0;
            cfgEdges_q <= '0;
            edgeCnt_q  <= '0;
            shadow_q   <= '0;
            tclk_q     <= 1'b0;
            td_q       <= 1'b0;
            tclrN_q    <= 1'b1;
            tsetN_q    <= 1'b1;
            expQ_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cfgLow_q   <= cfgLow_d;
            cfgHigh_q  <= cfgHigh_d;
            cfgSetup_q <= cfgSetup_d;
            cfgCtrl_q  <= cfgCtrl_d;
            cfgEdges_q <= cfgEdges_d;
            edgeCnt_q  <= edgeCnt_d;
            shadow_q   <= shadow_d;
            tclk_q     <= tclk_d;
            td_q       <= td_d;
            tclrN_q    <= tclrN_d;
            tsetN_q    <= tsetN_d;
            expQ_q     <= expQ_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef FLOP_STIM_VIOL_INJ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            viol_q  <= viol_d;
        end
    end

    assign stim_io.viol_exp = viol_q;
`endif

    assign stim_io.tclk     = tclk_q;
    assign stim_io.td       = td_q;
    assign stim_io.tclr_n   = tclrN_q;
    assign stim_io.tset_n   = tsetN_q;
    assign stim_io.exp_q    = expQ_q;
    assign stim_io.edge_cnt = edgeCnt_q;
    assign stim_io.busy     = busy_q;
    assign stim_io.done     = done_q;
endmodule

// File: tb/tb_flop_stim_gen.sv
// Directed testbench for flop_stim_gen: clear/set sequence, clock/data waveforms, wrap, reset abort.
// The injection test runs only when FLOP_STIM_VIOL_INJ_EN is defined.
module tb_flop_stim_gen;
    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;
    logic tdModel;

    flop_stim_gen_if #(.CNT_W(16), .PAT_W(32), .EDGE_W(16)) stimIf ();

    flop_stim_gen #(.CNT_W(16), .PAT_W(32), .EDGE_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .stim_io (stimIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Pulses start for one sampled edge, then scrambles the config to prove it was latched.
    task automatic applyStimulus(input int low, input int high, input int setup, input int ctrl,
                                 input int edges, input logic [31:0] pat);
        stimIf.cfg_low   = 16'(low);
        stimIf.cfg_high  = 16'(high);
        stimIf.cfg_setup = 16'(setup);
        stimIf.cfg_ctrl  = 16'(ctrl);
        stimIf.cfg_edges = 16'(edges);
        stimIf.cfg_pat   = pat;
        stimIf.start     = 1'b1;
        step();
        stimIf.start     = 1'b0;
        stimIf.cfg_low   = 16'd7;
        stimIf.cfg_high  = 16'd6;
        stimIf.cfg_setup = 16'd0;
        stimIf.cfg_ctrl  = 16'd9;
        stimIf.cfg_edges = 16'd1;
        stimIf.cfg_pat   = 32'hFFFF_FFFF;
    endtask

    // Runs a clock-only sequence and checks every cycle against the expected waveform.
    task automatic runClock(input string tag, input int low, input int high, input int setup,
                            input logic [31:0] pat, input int edges);
        int   lLen, hLen, chg;
        logic b, prev;
        lLen = (low == 0) ? 1 : low;
        hLen = (high == 0) ? 1 : high;
        chg  = (setup >= lLen) ? 0 : lLen - setup;
        prev = tdModel;
        applyStimulus(low, high, setup, 0, edges, pat);
        for (int e = 0; e < edges; e++) begin
            b = pat[e % 32];
            for (int i = 0; i < lLen; i++) begin
                checkOutput({tag, " low tclk"}, 32'(stimIf.tclk), 32'(1'b0));
                checkOutput({tag, " low td"}, 32'(stimIf.td), 32'((i >= chg) ? b : prev));
                step();
            end
            for (int j = 0; j < hLen; j++) begin
                checkOutput({tag, " high tclk"}, 32'(stimIf.tclk), 32'(1'b1));
                checkOutput({tag, " exp_q"}, 32'(stimIf.exp_q), 32'(b));
                checkOutput({tag, " edge_cnt"}, 32'(stimIf.edge_cnt), 32'(e + 1));
                checkOutput({tag, " busy"}, 32'(stimIf.busy), 32'(1'b1));
                step();
            end
            prev = b;
        end
        checkOutput({tag, " done"}, 32'(stimIf.done), 32'(1'b1));
        checkOutput({tag, " fin busy"}, 32'(stimIf.busy), 32'(1'b0));
        checkOutput({tag, " fin tclk"}, 32'(stimIf.tclk), 32'(1'b0));
        checkOutput({tag, " fin td"}, 32'(stimIf.td), 32'(prev));
        checkOutput({tag, " fin edge_cnt"}, 32'(stimIf.edge_cnt), 32'(edges));
        step();
        checkOutput({tag, " done pulse"}, 32'(stimIf.done), 32'(1'b0));
        tdModel = prev;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " tclk"}, 32'(stimIf.tclk), 32'(1'b0));
        checkOutput({tag, " td"}, 32'(stimIf.td), 32'(1'b0));
        checkOutput({tag, " tclr_n"}, 32'(stimIf.tclr_n), 32'(1'b1));
        checkOutput({tag, " tset_n"}, 32'(stimIf.tset_n), 32'(1'b1));
        checkOutput({tag, " exp_q"}, 32'(stimIf.exp_q), 32'(1'b0));
        checkOutput({tag, " edge_cnt"}, 32'(stimIf.edge_cnt), 32'(0));
        checkOutput({tag, " busy"}, 32'(stimIf.busy), 32'(1'b0));
        checkOutput({tag, " done"}, 32'(stimIf.done), 32'(1'b0));
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        tdModel       = 1'b0;
        rst           = 1'b1;
        stimIf.start     = 1'b0;
        stimIf.cfg_low   = '0;
        stimIf.cfg_high  = '0;
        stimIf.cfg_setup = '0;
        stimIf.cfg_ctrl  = '0;
        stimIf.cfg_edges = '0;
        stimIf.cfg_pat   = '0;
`ifdef FLOP_STIM_VIOL_INJ_EN
        stimIf.inject    = 1'b0;
`endif
        step();
        step();
        checkResetState("reset");
        rst = 1'b0;
        step();

        // Clear/set only: three low cycles of each, then done.
        applyStimulus(5, 4, 2, 3, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ctrl tclr_n", 32'(stimIf.tclr_n), 32'(1'b0));
            checkOutput("ctrl tset_n", 32'(stimIf.tset_n), 32'(1'b1));
            checkOutput("ctrl exp_q clr", 32'(stimIf.exp_q), 32'(1'b0));
            checkOutput("ctrl busy", 32'(stimIf.busy), 32'(1'b1));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput("ctrl tclr_n rel", 32'(stimIf.tclr_n), 32'(1'b1));
            checkOutput("ctrl tset_n", 32'(stimIf.tset_n), 32'(1'b0));
            checkOutput("ctrl exp_q set", 32'(stimIf.exp_q), 32'(1'b1));
            checkOutput("ctrl done early", 32'(stimIf.done), 32'(1'b0));
            step();
        end
        checkOutput("ctrl tset_n rel", 32'(stimIf.tset_n), 32'(1'b1));
        checkOutput("ctrl done", 32'(stimIf.done), 32'(1'b1));
        checkOutput("ctrl busy end", 32'(stimIf.busy), 32'(1'b0));
        checkOutput("ctrl tclk", 32'(stimIf.tclk), 32'(1'b0));
        step();
        checkOutput("ctrl done pulse", 32'(stimIf.done), 32'(1'b0));

        runClock("basic", 5, 4, 2, 32'hA, 4);
        runClock("setup10", 3, 2, 10, 32'h2, 2);
        runClock("toggle", 0, 0, 1, 32'h5, 3);
        runClock("wrap", 1, 1, 1, 32'h1, 33);

        // Reset abort during the third high phase.
        applyStimulus(2, 3, 1, 0, 5, 32'h6);
        repeat (12) step();
        checkOutput("abort pos tclk", 32'(stimIf.tclk), 32'(1'b1));
        checkOutput("abort pos edge_cnt", 32'(stimIf.edge_cnt), 32'(3));
        rst = 1'b1;
        step();
        checkResetState("abort");
        rst = 1'b0;
        tdModel = 1'b0;
        step();
        checkOutput("abort no done", 32'(stimIf.done), 32'(1'b0));
        checkOutput("abort idle busy", 32'(stimIf.busy), 32'(1'b0));
        runClock("rerun", 5, 4, 2, 32'hA, 4);

`ifdef FLOP_STIM_VIOL_INJ_EN
        // Inject during LOW: td is held until the rise, then both move together.
        applyStimulus(5, 2, 2, 0, 2, 32'h2);
        checkOutput("inj td hold0", 32'(stimIf.td), 32'(1'b1));
        stimIf.inject = 1'b1;
        step();
        stimIf.inject = 1'b0;
        checkOutput("inj viol early", 32'(stimIf.viol_exp), 32'(1'b0));
        step();
        step();
        checkOutput("inj td held", 32'(stimIf.td), 32'(1'b1));
        step();
        checkOutput("inj tclk low", 32'(stimIf.tclk), 32'(1'b0));
        step();
        checkOutput("inj tclk rise", 32'(stimIf.tclk), 32'(1'b1));
        checkOutput("inj td rise", 32'(stimIf.td), 32'(1'b0));
        checkOutput("inj viol", 32'(stimIf.viol_exp), 32'(1'b1));
        checkOutput("inj exp_q", 32'(stimIf.exp_q), 32'(1'b0));
        step();
        checkOutput("inj viol pulse", 32'(stimIf.viol_exp), 32'(1'b0));
        repeat (4) step();
        checkOutput("inj next td", 32'(stimIf.td), 32'(1'b1));
        step();
        step();
        checkOutput("inj next exp_q", 32'(stimIf.exp_q), 32'(1'b1));
        checkOutput("inj next viol", 32'(stimIf.viol_exp), 32'(1'b0));
        checkOutput("inj next edge", 32'(stimIf.edge_cnt), 32'(2));
        step();
        step();
        checkOutput("inj done", 32'(stimIf.done), 32'(1'b1));
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule

// File: doc/flop_stim_gen.md
Name: flop_stim_gen

Overview:
- Synthesizable stimulus sequencer that drives the clk/d/clr/set pins of a clear/set D flip-flop under test, the driving end of that flop's input interface.
- Generates a programmable clock waveform, a data stream with a programmable setup offset, and an initial clear/set sequence.
- Produces the expected q value for scoreboard comparison.
- Sits in the bench/BIST wrapper beside the flop cell and its specify-block timing checks.

Parameters:
CNT_W, 16, width of all phase/duration counters and cfg fields
PAT_W, 32, width of the data pattern register
EDGE_W, 16, width of the rising-edge counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to run a sequence; sampled only in IDLE
cfg_low  input  CNT_W  tclk low-phase length in clk cycles (0 treated as 1)
cfg_high  input  CNT_W  tclk high-phase length in clk cycles (0 treated as 1)
cfg_setup  input  CNT_W  cycles td is stable before each tclk rise
cfg_ctrl  input  CNT_W  length of each clear and set pulse (0 skips the control phase)
cfg_edges  input  EDGE_W  number of tclk rising edges to generate (0 means no clock phase)
cfg_pat  input  PAT_W  data pattern, consumed LSB first, wraps
tclk  output  1  clock to DUT
td  output  1  data to DUT
tclr_n  output  1  active-low clear to DUT
tset_n  output  1  active-low set to DUT
exp_q  output  1  expected DUT q after the latest event
edge_cnt  output  EDGE_W  rising edges generated so far
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when the sequence ends

Behaviour:
- All outputs are registered.
- Reset values: tclk=0, td=0, tclr_n=1, tset_n=1, exp_q=0, edge_cnt=0, busy=0, done=0, FSM=IDLE. Reset mid-sequence aborts on the next edge with no done pulse.
- Config fields and cfg_pat are latched on start acceptance. Changes while busy are ignored.
- States: IDLE, CLR, SET, LOW, HIGH, FIN.
- IDLE:
  - start=1 sets busy=1 and edge_cnt=0, and loads the pattern shadow.
  - Next state is CLR if cfg_ctrl≠0; otherwise LOW if cfg_edges≠0; otherwise FIN.
  - start while busy is ignored.
- CLR: tclr_n=0 for cfg_ctrl cycles; exp_q=0 from the first CLR cycle. Then goes to SET.
- SET:
  - tclr_n=1 and tset_n=0 together on the same edge, for cfg_ctrl cycles.
  - exp_q=1 (set dominates).
  - Then tset_n=1, and the FSM goes to LOW (or FIN if cfg_edges=0).
- LOW:
  - tclk=0 for L=max(cfg_low,1) cycles.
  - td takes the next pattern bit at LOW cycle index max(L−cfg_setup,0), counting from 0. If cfg_setup≥L, td changes on the first LOW cycle.
  - Then goes to HIGH.
- HIGH:
  - tclk=1 for max(cfg_high,1) cycles.
  - On entry: edge_cnt increments, exp_q takes the current td, and the pattern shadow rotates right by 1.
  - After the last HIGH cycle: FIN if edge_cnt==cfg_edges, else LOW.
- FIN: tclk=0 and td holds; done=1 for exactly one cycle, busy=0 on the same edge; returns to IDLE.
  - start asserted in the FIN cycle is ignored.
  - start asserted in the following IDLE cycle is accepted.
- Counter rules: edge_cnt saturates at all-ones. Phase counters count down and reload on each state entry.
- Pattern wrap: bit PAT_W−1 is followed by bit 0.

Optional Feature:
Macro FLOP_STIM_VIOL_INJ_EN.
- Enabled:
  - Adds input inject (1) and output viol_exp (1), reset 0.
  - An inject pulse while busy arms a one-shot. On the next LOW→HIGH transition, td updates on the same edge as tclk rises (zero setup), exp_q=x-free 0, and viol_exp pulses for 1 cycle.
  - The DUT's setup check is expected to fire there.
  - The one-shot clears after use. Inject outside LOW/HIGH is held until the next rise.
- Disabled: ports are absent; behaviour is exactly as above.

Test Plan:
- Reset then start with cfg_ctrl=3, cfg_edges=0 -> tclr_n low cycles 2-4, tset_n low cycles 5-7, exp_q 0 then 1, done pulse at cycle 8, busy low from cycle 8.
- cfg_low=5, cfg_high=4, cfg_setup=2, cfg_pat=32'hA, cfg_edges=4, cfg_ctrl=0 -> tclk period 9 cycles, td changes 2 cycles before each rise, exp_q sequence 0,1,0,1, edge_cnt=4, one done.
- cfg_setup=10, cfg_low=3 -> td changes on the first LOW cycle. cfg_low=0, cfg_high=0 -> 1/1 toggle.
- cfg_edges=33, cfg_pat=32'h1 -> exp_q=1 on edges 1 and 33 only (wrap).
- rst asserted in the 3rd HIGH phase -> next edge all outputs at reset values, no done; new start runs normally.
- With FLOP_STIM_VIOL_INJ_EN: inject during LOW -> td and tclk change on the same edge, viol_exp=1 for one cycle, later edges normal.
